// File: rtl/ppfifo_read_arbiter_if.sv
// Bundle of the two ppfifo read ports and the shared downstream valid/ready stream.
// master is the arbiter's view; slave is the view of the ppfifos and sink around it.
interface ppfifo_read_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic [1:0]              in_read_ready;
    logic [47:0]             in_read_count;
    logic [2*DATA_WIDTH-1:0] in_read_data;
    logic [1:0]              in_read_activate;
    logic [1:0]              in_read_strobe;
    logic                    o_valid;
    logic                    o_ready;
    logic [DATA_WIDTH-1:0]   o_data;
    logic                    o_last;
    logic                    o_source;

    modport master (
        input  in_read_ready, in_read_count, in_read_data, o_ready,
        output in_read_activate, in_read_strobe, o_valid, o_data, o_last, o_source
    );

    modport slave (
        output in_read_ready, in_read_count, in_read_data, o_ready,
        input  in_read_activate, in_read_strobe, o_valid, o_data, o_last, o_source
    );
endinterface

// File: rtl/ppfifo_read_arbiter.sv
// Round-robin arbiter draining whole blocks from two ppfifo read sides into one
// registered valid/ready stream, marking the final word of each block with o_last.
module ppfifo_read_arbiter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                 read_clock,
    input  logic                 reset,
    input  logic                 enable,
    ppfifo_read_arbiter_if.master bus,
    output logic                 busy,
    output logic                 block_done
);

    typedef enum logic [1:0] {IDLE, STREAM, RELEASE} state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic                  r_grant;
    logic                  r_priority;
    logic [23:0]           r_remaining;
    logic [1:0]            r_activate;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;
    logic                  r_source;

    logic                  w_outFree;
    logic                  w_grantNow;
    logic                  w_load;
    logic                  w_pick;
    logic [23:0]           w_pickCount;
    logic [DATA_WIDTH-1:0] w_grantData;

    // With both requesting, the pointer names the favoured fifo; otherwise take whichever asks.
    assign w_pick      = (bus.in_read_ready == 2'b11) ? r_priority : bus.in_read_ready[1];
    assign w_pickCount = w_pick ? bus.in_read_count[47:24] : bus.in_read_count[23:0];
    assign w_grantData = r_grant ? bus.in_read_data[2*DATA_WIDTH-1:DATA_WIDTH]
                                 : bus.in_read_data[DATA_WIDTH-1:0];
    assign w_outFree   = !r_valid || bus.o_ready;

    always_ff @(posedge read_clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A new block waits for the output register to empty so blocks never interleave.
    always_comb begin
        w_nextState = r_state;
        w_grantNow  = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && (|bus.in_read_ready) && w_outFree) begin
                    w_grantNow  = 1'b1;
                    w_nextState = STREAM;
                end
            end
            STREAM: begin
                if (r_remaining == 24'd0) begin
                    w_nextState = RELEASE;
                end else begin
                    w_load = w_outFree;
                end
            end
            RELEASE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge read_clock or posedge reset) begin
        if (reset) begin
            r_grant     <= 1'b0;
            r_priority  <= 1'b0;
            r_remaining <= 24'd0;
            r_activate  <= 2'b00;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_last      <= 1'b0;
            r_source    <= 1'b0;
        end else begin
            if (w_grantNow) begin
                r_grant     <= w_pick;
                r_remaining <= w_pickCount;
                r_activate  <= w_pick ? 2'b10 : 2'b01;
            end else if (r_state == STREAM && r_remaining == 24'd0) begin
                r_activate <= 2'b00;
            end

            if (w_load) begin
                r_data      <= w_grantData;
                r_source    <= r_grant;
                r_valid     <= 1'b1;
                r_last      <= (r_remaining == 24'd1);
                r_remaining <= r_remaining - 24'd1;
            end else if (bus.o_ready) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end

            if (r_state == RELEASE) begin
                r_priority <= ~r_grant;
            end
        end
    end

    assign bus.in_read_strobe   = {w_load & r_grant, w_load & ~r_grant};
    assign bus.in_read_activate = r_activate;
    assign bus.o_valid          = r_valid;
    assign bus.o_data           = r_data;
    assign bus.o_last           = r_last;
    assign bus.o_source         = r_source;
    assign busy                 = (r_state != IDLE);
    assign block_done           = (r_state == RELEASE);

endmodule
